i2c_master_slave_bfm: RTL and testbench



---
 rtl/i2c_master_slave_bfm.sv | 267 ++++++++++++++++++++++++++
 tb/tb_i2c_master_slave_bfm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_slave_bfm.sv
// rtl/i2c_master_slave_bfm.sv - I2C master and 7-bit register-file slave joined by a wired-AND SCL/SDA pair
module i2c_master_slave_bfm #(
   parameter logic [6:0] SLAVE_ADDR = 7'h68,
   parameter int         CLK_DIV    = 4
) (
   input  logic       pclk,
   input  logic       areset,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [3:0] reg_ptr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [7:0] rdata,
   output logic       scl,
   output logic       sda
);
   localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [3:0] M_IDLE   = 4'd0;
   localparam logic [3:0] M_START  = 4'd1;
   localparam logic [3:0] M_ADDR   = 4'd2;
   localparam logic [3:0] M_ACK_A  = 4'd3;
   localparam logic [3:0] M_REG    = 4'd4;
   localparam logic [3:0] M_ACK_R  = 4'd5;
   localparam logic [3:0] M_DATA_W = 4'd6;
   localparam logic [3:0] M_ACK_D  = 4'd7;
   localparam logic [3:0] M_DATA_R = 4'd8;
   localparam logic [3:0] M_NACK_M = 4'd9;
   localparam logic [3:0] M_STOP   = 4'd10;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_REG   = 3'd2;
   localparam logic [2:0] S_WDATA = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   logic [3:0]    state;
   logic [DW-1:0] div_cnt;
   logic [1:0]    quarter;
   logic [2:0]    bit_cnt;
   logic [7:0]    tx_shift;
   logic [7:0]    rx_shift;
   logic          cmd_rw;
   logic [3:0]    cmd_reg;
   logic [7:0]    cmd_wdata;
   logic          scl_m;
   logic          sda_m;
   logic          tick;
   logic          period_end;
   logic          sample;

   logic [2:0] s_state;
   logic [3:0] s_bit;
   logic [7:0] s_rx;
   logic [7:0] s_tx;
   logic       s_sda;
   logic       scl_q;
   logic       sda_q;
   logic [3:0] ptr;
   logic [7:0] regs [16];
   logic       rise;
   logic       fall;
   logic       start_det;
   logic       stop_det;
   logic       s_active;

   assign tick       = (div_cnt == DIV_LAST);
   assign period_end = tick && (quarter == 2'd3);
   // receivers sample once, in the first cycle of Q2
   assign sample     = (div_cnt == '0) && (quarter == 2'd2);
   assign busy       = (state != M_IDLE);

   assign scl = scl_m;
   assign sda = sda_m & s_sda;

   assign rise      = scl & ~scl_q;
   assign fall      = ~scl & scl_q;
   // both SCL samples high so a simultaneous SCL-fall/SDA-change is never a START/STOP
   assign start_det = scl & scl_q & sda_q & ~sda;
   assign stop_det  = scl & scl_q & ~sda_q & sda;
   assign s_active  = (s_state != S_IDLE) && (s_state != S_WAIT);

   // master bus drive decoded from state, quarter and the transmit shifter
   always_comb begin
      scl_m = 1'b1;
      sda_m = 1'b1;
      case (state)
         M_IDLE:  sda_m = 1'b1;
         M_START: sda_m = ~quarter[1];
         M_ADDR, M_REG, M_DATA_W: begin
            scl_m = quarter[1];
            sda_m = tx_shift[7];
         end
         M_STOP: begin
            scl_m = quarter[1];
            sda_m = (quarter == 2'd3);
         end
         default: scl_m = quarter[1];
      endcase
   end

   // master sequencer: command capture, bit timing, ACK checking and read capture
   always_ff @(posedge pclk or negedge areset) begin
      if (!areset) begin
         state     <= M_IDLE;
         div_cnt   <= '0;
         quarter   <= 2'd0;
         bit_cnt   <= 3'd7;
         tx_shift  <= 8'hFF;
         rx_shift  <= 8'h00;
         cmd_rw    <= 1'b0;
         cmd_reg   <= 4'd0;
         cmd_wdata <= 8'h00;
         done      <= 1'b0;
         ack_err   <= 1'b0;
         rdata     <= 8'h00;
      end else begin
         done <= 1'b0;
         if (state == M_IDLE) begin
            div_cnt <= '0;
            quarter <= 2'd0;
            if (start) begin
               state     <= M_START;
               ack_err   <= 1'b0;
               cmd_rw    <= rw;
               cmd_reg   <= reg_ptr;
               cmd_wdata <= wdata;
               tx_shift  <= {addr, rw};
               bit_cnt   <= 3'd7;
            end
         end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
               quarter <= quarter + 2'd1;
            if (sample) begin
               if ((state == M_ACK_A || state == M_ACK_R || state == M_ACK_D) && sda)
                  ack_err <= 1'b1;
               if (state == M_DATA_R)
                  rx_shift <= {rx_shift[6:0], sda};
            end
            if (period_end) begin
               case (state)
                  M_START: begin
                     state   <= M_ADDR;
                     bit_cnt <= 3'd7;
                  end
                  M_ADDR, M_REG, M_DATA_W: begin
                     tx_shift <= {tx_shift[6:0], 1'b0};
                     bit_cnt  <= bit_cnt - 3'd1;
                     if (bit_cnt == 3'd0)
                        state <= state + 4'd1;
                  end
                  M_ACK_A: begin
                     if (ack_err)
                        state <= M_STOP;
                     else if (cmd_rw)
                        state <= M_DATA_R;
                     else begin
                        state    <= M_REG;
                        tx_shift <= {4'b0000, cmd_reg};
                     end
                  end
                  M_ACK_R: begin
                     if (ack_err)
                        state <= M_STOP;
                     else begin
                        state    <= M_DATA_W;
                        tx_shift <= cmd_wdata;
                     end
                  end
                  M_ACK_D: state <= M_STOP;
                  M_DATA_R: begin
                     bit_cnt <= bit_cnt - 3'd1;
                     if (bit_cnt == 3'd0)
                        state <= M_NACK_M;
                  end
                  M_NACK_M: state <= M_STOP;
                  M_STOP: begin
                     state <= M_IDLE;
                     done  <= 1'b1;
                     if (cmd_rw && !ack_err)
                        rdata <= rx_shift;
                  end
                  default: state <= M_IDLE;
               endcase
            end
         end
      end
   end

   // slave: bus-condition detection, byte reception, ACK drive and register file access
   always_ff @(posedge pclk or negedge areset) begin
      if (!areset) begin
         s_state <= S_IDLE;
         s_bit   <= 4'd0;
         s_rx    <= 8'h00;
         s_tx    <= 8'h00;
         s_sda   <= 1'b1;
         scl_q   <= 1'b1;
         sda_q   <= 1'b1;
         ptr     <= 4'd0;
         for (int i = 0; i < 16; i++)
            regs[i] <= 8'h00;
      end else begin
         scl_q <= scl;
         sda_q <= sda;
         if (start_det) begin
            s_state <= S_ADDR;
            s_bit   <= 4'd0;
            s_sda   <= 1'b1;
         end else if (stop_det) begin
            s_state <= S_IDLE;
            s_bit   <= 4'd0;
            s_sda   <= 1'b1;
         end else if (s_active && rise) begin
            if (s_bit < 4'd8) begin
               s_rx  <= {s_rx[6:0], sda};
               s_bit <= s_bit + 4'd1;
            end else begin
               // 9th clock; in a read this is the master's ACK/NACK
               s_bit <= 4'd9;
               if (s_state == S_RDATA && sda)
                  s_state <= S_WAIT;
            end
         end else if (s_active && fall) begin
            if (s_bit == 4'd8) begin
               case (s_state)
                  S_ADDR: begin
                     if (s_rx[7:1] == SLAVE_ADDR) begin
                        s_sda   <= 1'b0;
                        s_state <= s_rx[0] ? S_RDATA : S_REG;
                     end else
                        s_state <= S_WAIT;
                  end
                  S_REG: begin
                     ptr     <= s_rx[3:0];
                     s_sda   <= 1'b0;
                     s_state <= S_WDATA;
                  end
                  S_WDATA: begin
                     regs[ptr] <= s_rx;
                     ptr       <= ptr + 4'd1;
                     s_sda     <= 1'b0;
                  end
                  default: s_sda <= 1'b1;
               endcase
            end else if (s_bit == 4'd9) begin
               s_bit <= 4'd0;
               if (s_state == S_RDATA) begin
                  s_sda <= regs[ptr][7];
                  s_tx  <= {regs[ptr][6:0], 1'b0};
                  ptr   <= ptr + 4'd1;
               end else
                  s_sda <= 1'b1;
            end else if (s_state == S_RDATA && s_bit != 4'd0) begin
               s_sda <= s_tx[7];
               s_tx  <= {s_tx[6:0], 1'b0};
            end
         end
      end
   end
endmodule

// File: tb/tb_i2c_master_slave_bfm.sv
// tb/tb_i2c_master_slave_bfm.sv - scoreboard bench for the I2C master/slave link
module tb_i2c_master_slave_bfm;
   logic       pclk;
   logic       areset;
   logic       start;
   logic       start1;
   logic       rw;
   logic [6:0] addr;
   logic [3:0] reg_ptr;
   logic [7:0] wdata;
   logic       busy, done, ack_err, scl, sda;
   logic [7:0] rdata;
   logic       busy1, done1, ack_err1, scl1, sda1;
   logic [7:0] rdata1;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] model_regs [16];
   logic [3:0] model_ptr;
   logic [7:0] model_rdata;

   typedef struct {
      int         lat;
      logic       err;
      logic [7:0] rdat;
      logic [3:0] ptr;
   } exp_t;
   exp_t sb [$];

   int         cyc1;
   logic       got1;
   logic [1:0] w1 [0:199];
   logic [31:0] v1;

   i2c_master_slave_bfm #(.SLAVE_ADDR(7'h68), .CLK_DIV(4)) dut (
      .pclk(pclk), .areset(areset), .start(start), .rw(rw), .addr(addr),
      .reg_ptr(reg_ptr), .wdata(wdata), .busy(busy), .done(done),
      .ack_err(ack_err), .rdata(rdata), .scl(scl), .sda(sda)
   );

   i2c_master_slave_bfm #(.SLAVE_ADDR(7'h68), .CLK_DIV(1)) dut1 (
      .pclk(pclk), .areset(areset), .start(start1), .rw(rw), .addr(addr),
      .reg_ptr(reg_ptr), .wdata(wdata), .busy(busy1), .done(done1),
      .ack_err(ack_err1), .rdata(rdata1), .scl(scl1), .sda(sda1)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // {scl,sda} per cycle over one START or STOP period of 4*d cycles
   function automatic logic [31:0] exp_edge(input int d, input bit is_stop);
      logic [31:0] v;
      int q;
      v = '0;
      for (int i = 0; i < 4 * d; i++) begin
         q = i / d;
         if (is_stop)
            v = {v[29:0], (q >= 2), (q == 3)};
         else
            v = {v[29:0], 1'b1, (q < 2)};
      end
      return v;
   endfunction

   task automatic run_txn(input logic t_rw, input logic [6:0] t_addr, input logic [3:0] t_reg,
                          input logic [7:0] t_wdata, input int poke_cyc, input string tag);
      exp_t        e;
      logic [1:0]  wave [0:599];
      int          cyc;
      logic        got;
      logic [31:0] obs_v;
      if (t_addr != 7'h68) begin
         e.err = 1'b1;
         e.lat = 11 * 16;
      end else if (t_rw) begin
         e.err       = 1'b0;
         e.lat       = 20 * 16;
         model_rdata = model_regs[model_ptr];
         model_ptr   = model_ptr + 4'd1;
      end else begin
         e.err             = 1'b0;
         e.lat             = 29 * 16;
         model_regs[t_reg] = t_wdata;
         model_ptr         = t_reg + 4'd1;
      end
      e.rdat = model_rdata;
      e.ptr  = model_ptr;
      sb.push_back(e);

      @(negedge pclk);
      rw = t_rw; addr = t_addr; reg_ptr = t_reg; wdata = t_wdata; start = 1'b1;
      @(posedge pclk);
      #1;
      start = 1'b0;
      check_eq({tag, " busy_on"}, 32'(busy), 32'd1);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 1000) begin
         if (cyc < 600)
            wave[cyc] = {scl, sda};
         if (cyc == poke_cyc) begin
            start = 1'b1;
            rw    = ~t_rw;
            addr  = 7'h10;
         end
         @(posedge pclk);
         #1;
         start = 1'b0;
         cyc++;
         if (done)
            got = 1'b1;
      end

      e = sb.pop_front();
      check_eq({tag, " done_seen"}, 32'(got), 32'd1);
      check_eq({tag, " latency"}, 32'(cyc), 32'(e.lat));
      check_eq({tag, " busy_at_done"}, 32'(busy), 32'd0);
      check_eq({tag, " ack_err"}, 32'(ack_err), 32'(e.err));
      check_eq({tag, " rdata"}, 32'(rdata), 32'(e.rdat));
      check_eq({tag, " ptr"}, 32'(dut.ptr), 32'(e.ptr));
      if (got && cyc >= 176 && cyc <= 600) begin
         obs_v = '0;
         for (int i = 0; i < 16; i++)
            obs_v = {obs_v[29:0], wave[i]};
         check_eq({tag, " start_wave"}, obs_v, exp_edge(4, 1'b0));
         obs_v = '0;
         for (int i = cyc - 16; i < cyc; i++)
            obs_v = {obs_v[29:0], wave[i]};
         check_eq({tag, " stop_wave"}, obs_v, exp_edge(4, 1'b1));
         check_eq({tag, " addr_ack_sda"}, 32'(wave[152][0]), 32'(e.err));
      end
      @(posedge pclk);
      #1;
      check_eq({tag, " done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      areset = 1'b0;
      start = 1'b0; start1 = 1'b0; rw = 1'b0;
      addr = 7'h00; reg_ptr = 4'd0; wdata = 8'h00;
      for (int i = 0; i < 16; i++)
         model_regs[i] = 8'h00;
      model_ptr   = 4'd0;
      model_rdata = 8'h00;

      repeat (3) @(posedge pclk);
      #1;
      check_eq("rst busy", 32'(busy), 32'd0);
      check_eq("rst done", 32'(done), 32'd0);
      check_eq("rst ack_err", 32'(ack_err), 32'd0);
      check_eq("rst rdata", 32'(rdata), 32'd0);
      check_eq("rst scl", 32'(scl), 32'd1);
      check_eq("rst sda", 32'(sda), 32'd1);
      check_eq("rst ptr", 32'(dut.ptr), 32'd0);
      @(negedge pclk);
      areset = 1'b1;
      repeat (2) @(posedge pclk);

      run_txn(1'b0, 7'h68, 4'd3, 8'hA5, -1, "wr1");
      check_eq("wr1 reg3", 32'(dut.regs[3]), 32'(model_regs[3]));
      run_txn(1'b0, 7'h68, 4'd3, 8'h5A, -1, "wr2");
      run_txn(1'b1, 7'h68, 4'd0, 8'h00, -1, "rd1");
      run_txn(1'b0, 7'h68, 4'd2, 8'h77, -1, "wr3");
      run_txn(1'b1, 7'h68, 4'd0, 8'h00, -1, "rd2");
      run_txn(1'b0, 7'h68, 4'd15, 8'h11, -1, "wr15");
      run_txn(1'b1, 7'h68, 4'd0, 8'h00, -1, "rd_wrap");
      run_txn(1'b0, 7'h10, 4'd5, 8'hEE, -1, "nack");
      check_eq("nack reg5", 32'(dut.regs[5]), 32'(model_regs[5]));
      check_eq("nack reg3", 32'(dut.regs[3]), 32'(model_regs[3]));
      run_txn(1'b0, 7'h68, 4'd5, 8'hC3, 100, "poke");
      check_eq("poke reg5", 32'(dut.regs[5]), 32'(model_regs[5]));

      @(negedge pclk);
      rw = 1'b0; addr = 7'h68; reg_ptr = 4'd9; wdata = 8'h66; start = 1'b1;
      @(posedge pclk);
      #1;
      start = 1'b0;
      repeat (50) @(posedge pclk);
      #1;
      check_eq("pre_rst scl", 32'(scl), 32'd0);
      areset = 1'b0;
      #1;
      check_eq("mid_rst busy", 32'(busy), 32'd0);
      check_eq("mid_rst scl", 32'(scl), 32'd1);
      check_eq("mid_rst sda", 32'(sda), 32'd1);
      check_eq("mid_rst reg5", 32'(dut.regs[5]), 32'd0);
      for (int i = 0; i < 16; i++)
         model_regs[i] = 8'h00;
      model_ptr   = 4'd0;
      model_rdata = 8'h00;
      @(negedge pclk);
      areset = 1'b1;
      repeat (2) @(posedge pclk);

      run_txn(1'b0, 7'h68, 4'd7, 8'h3C, -1, "post_wr7");
      run_txn(1'b0, 7'h68, 4'd6, 8'h99, -1, "post_wr6");
      run_txn(1'b1, 7'h68, 4'd0, 8'h00, -1, "post_rd");

      @(negedge pclk);
      rw = 1'b0; addr = 7'h68; reg_ptr = 4'd9; wdata = 8'h42; start1 = 1'b1;
      @(posedge pclk);
      #1;
      start1 = 1'b0;
      cyc1 = 0;
      got1 = 1'b0;
      while (!got1 && cyc1 < 400) begin
         if (cyc1 < 200)
            w1[cyc1] = {scl1, sda1};
         @(posedge pclk);
         #1;
         cyc1++;
         if (done1)
            got1 = 1'b1;
      end
      check_eq("div1 latency", 32'(cyc1), 32'd116);
      check_eq("div1 ack_err", 32'(ack_err1), 32'd0);
      check_eq("div1 reg9", 32'(dut1.regs[9]), 32'h42);
      if (got1 && cyc1 >= 8 && cyc1 <= 200) begin
         v1 = '0;
         for (int i = 0; i < 4; i++)
            v1 = {v1[29:0], w1[i]};
         check_eq("div1 start_wave", v1, exp_edge(1, 1'b0));
         v1 = '0;
         for (int i = cyc1 - 4; i < cyc1; i++)
            v1 = {v1[29:0], w1[i]};
         check_eq("div1 stop_wave", v1, exp_edge(1, 1'b1));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
